// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for the FIFO read-side stream adapter, so the FIFO and the
// adapter agree on word width and burst framing defaults.
package fifo_rd_stream_pkg;

    localparam int FIFO_WIDTH        = 16;
    localparam int FIFO_DEPTH        = 32;
    localparam int BURST_LEN_DEFAULT = 4;
    localparam int CNT_W_DEFAULT     = 16;

    // Bits needed to hold 0..n-1; never less than one so BURST_LEN=1 still has a counter.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_skid_buf2.sv
// Two-entry (head + skid) buffer between the FIFO read port and the output
// stream; absorbs the word still in flight when the consumer stalls.
module skid_buf2
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ
);

    // Handshakes: a word moves out on a cycle with out_valid && out_ready;
    // in_valid has no ready because the producer only issues a word when it
    // has already reserved room (occ + in-flight - outgoing < 2).
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [1:0]       occ_q, occ_d;
    logic             pop;
    logic             push;

    always_comb begin
        pop    = (occ_q != 2'd0) && out_ready;
        push   = in_valid && !flush;
        head_d = head_q;
        skid_d = skid_q;
        occ_d  = occ_q;

        if (pop && (occ_q == 2'd2)) begin
            head_d = skid_q;
        end

        if (push) begin
            if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)) begin
                head_d = in_data;
            end else if ((occ_q == 2'd1) || pop) begin
                skid_d = in_data;
            end
        end

        case ({push, pop})
            2'b10:   occ_d = (occ_q == 2'd2) ? occ_q : occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        // Handshake of this cycle already happened; flush only clears what remains.
        if (flush) begin
            occ_d = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            skid_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            skid_q <= skid_d;
            occ_q  <= occ_d;
        end
    end

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = head_q;
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side adapter: pops the FIFO, hides its one-cycle read latency with
// a 2-entry skid buffer and frames the stream into fixed-length bursts.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int BURST_LEN = BURST_LEN_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [CNT_W-1:0] burst_cnt
);

    localparam int                BEAT_W    = clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic              inflight_q, inflight_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [1:0]        occ;
    logic              pop_out;
    logic [2:0]        fill;

    skid_buf2 #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (inflight_q),
        .in_data  (fifo_rd_data),
        .out_valid(m_valid),
        .out_ready(m_ready),
        .out_data (m_data),
        .occ      (occ)
    );

    always_comb begin
        pop_out = m_valid && m_ready;
        // Words the buffer will hold after this edge, before any new pop lands.
        fill        = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop_out};
        fifo_rd_en  = !rst && !fifo_empty && !flush && (fill < 3'd2);
        inflight_d  = fifo_rd_en;
        m_last      = m_valid && (beat_q == LAST_BEAT);
        beat_d      = beat_q;
        burst_cnt_d = burst_cnt_q;

        if (pop_out) begin
            if (m_last) begin
                beat_d      = '0;
                burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end

        if (flush) begin
            beat_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q  <= 1'b0;
            beat_q      <= '0;
            burst_cnt_q <= '0;
        end else begin
            inflight_q  <= inflight_d;
            beat_q      <= beat_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a behavioural FIFO feeds the adapter, a
// scoreboard queue holds the expected {last, data} beats in delivery order.
module tb_fifo_rd_stream;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] fifo_rd_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_last;
    logic [15:0] burst_cnt;

    fifo_rd_stream dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .burst_cnt   (burst_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural FIFO ----------------
    logic [15:0] fifo_mem [0:255];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    initial fifo_rd_data = 16'h0000;
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= fifo_mem[rd_ptr];
            rd_ptr       <= rd_ptr + 8'd1;
        end else begin
            fifo_rd_data <= 16'hBAD0;
        end
    end

    // ---------------- scoreboard ----------------
    logic [16:0] exp_q[$];
    int          hs_times[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_hs     = 0;
    int          n_pop    = 0;
    int          cyc      = 0;
    int          occ_m    = 0;
    int          infl_m   = 0;
    int          hs_now;
    int          pop_now;
    logic        exp_rd;
    logic        mon_en   = 1'b0;
    logic [16:0] exp_beat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Queue a word into the FIFO; keep=0 means the word is expected to be discarded.
    task automatic load(input logic [15:0] d, input logic last, input logic keep);
        fifo_mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 8'd1;
        if (keep) exp_q.push_back({last, d});
    endtask

    task automatic wait_hs(input int k, input string name);
        int target;
        target = n_hs + k;
        for (int i = 0; i < 200 && n_hs < target; i++) begin
            @(posedge clk);
            #1;
        end
        chk(name, 32'(n_hs >= target), 32'd1);
    endtask

    // Monitor: samples at the falling edge, where inputs and state are settled
    // for the rising edge that follows.
    always @(negedge clk) begin
        cyc++;
        if (!mon_en || rst) begin
            occ_m  = 0;
            infl_m = 0;
        end else begin
            hs_now  = (m_valid && m_ready) ? 1 : 0;
            pop_now = (fifo_rd_en && !fifo_empty) ? 1 : 0;
            chk("m_valid_vs_occ", 32'(m_valid), 32'(occ_m != 0));
            exp_rd = !fifo_empty && !flush && ((occ_m + infl_m - hs_now) < 2);
            chk("fifo_rd_en_rule", 32'(fifo_rd_en), 32'(exp_rd));
            if (hs_now == 1) begin
                n_hs++;
                hs_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    exp_beat = exp_q.pop_front();
                    chk("beat_data", 32'(m_data), 32'(exp_beat[15:0]));
                    chk("beat_last", 32'(m_last), 32'(exp_beat[16]));
                end
            end
            if (pop_now == 1) n_pop++;
            occ_m = flush ? 0 : occ_m + infl_m - hs_now;
            if (occ_m > 2) chk("occ_le_2", 32'(occ_m), 32'd2);
            infl_m = pop_now;
        end
    end

    // ---------------- stimulus ----------------
    int base;
    int p0;
    int target;

    initial begin
        rst     = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;

        // Reset asserted mid-cycle: outputs clear without waiting for an edge.
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_burst_cnt", 32'(burst_cnt), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_m_valid", 32'(m_valid), 32'd0);

        // Streaming: 8 words, bursts of 4, no gaps once flowing.
        m_ready = 1'b1;
        base = hs_times.size();
        for (int i = 1; i <= 8; i++) load(16'(i), (i % 4) == 0, 1'b1);
        wait_hs(8, "stream_done");
        chk("stream_gapless", 32'(hs_times[base + 7] - hs_times[base]), 32'd7);
        chk("stream_burst_cnt", 32'(burst_cnt), 32'd2);

        // Backpressure: 6 words, 5-cycle stall, at most 2 pops while stalled.
        m_ready = 1'b0;
        p0 = n_pop;
        load(16'h0021, 1'b0, 1'b1);
        load(16'h0022, 1'b0, 1'b1);
        load(16'h0023, 1'b0, 1'b1);
        load(16'h0024, 1'b1, 1'b1);
        load(16'h0025, 1'b0, 1'b1);
        load(16'h0026, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (m_valid) begin
                chk("stall_data", 32'(m_data), 32'h0021);
                chk("stall_last", 32'(m_last), 32'd0);
            end
        end
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_pops_le2", 32'((n_pop - p0) <= 2), 32'd1);
        m_ready = 1'b1;
        wait_hs(6, "bp_done");
        chk("bp_burst_cnt", 32'(burst_cnt), 32'd3);

        // Toggling ready: beat starts at 2, so last lands on 0x11, 0x15, 0x19.
        for (int i = 0; i < 10; i++) begin
            load(16'h0010 + 16'(i), (i == 1) || (i == 5) || (i == 9), 1'b1);
        end
        target = n_hs + 10;
        for (int i = 0; i < 80 && n_hs < target; i++) begin
            @(posedge clk);
            #1;
            m_ready = !m_ready;
        end
        chk("toggle_count", 32'(n_hs), 32'(target));
        chk("toggle_burst_cnt", 32'(burst_cnt), 32'd6);

        // Flush with occ=2: 0x31 handshakes in the flush cycle, 0x32 is dropped.
        m_ready = 1'b0;
        load(16'h0031, 1'b0, 1'b1);
        load(16'h0032, 1'b0, 1'b0);
        load(16'h0033, 1'b0, 1'b0);
        load(16'h0034, 1'b0, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("pre_flush_valid", 32'(m_valid), 32'd1);
        flush   = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        flush   = 1'b0;
        m_ready = 1'b0;
        chk("flush1_m_valid", 32'(m_valid), 32'd0);
        chk("flush1_burst_cnt", 32'(burst_cnt), 32'd6);
        // Now 0x33 is buffered next and 0x34 in flight: flush both.
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush2_m_valid", 32'(m_valid), 32'd0);
        // Framing restarts: last on the 4th new word.
        load(16'h0035, 1'b0, 1'b1);
        load(16'h0036, 1'b0, 1'b1);
        load(16'h0037, 1'b0, 1'b1);
        load(16'h0038, 1'b1, 1'b1);
        m_ready = 1'b1;
        wait_hs(4, "post_flush_done");
        chk("post_flush_burst_cnt", 32'(burst_cnt), 32'd7);

        // Reset after 2 of 4 beats: 0x43 and 0x44 are lost.
        m_ready = 1'b0;
        load(16'h0041, 1'b0, 1'b1);
        load(16'h0042, 1'b0, 1'b1);
        load(16'h0043, 1'b0, 1'b0);
        load(16'h0044, 1'b0, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        m_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_burst_cnt", 32'(burst_cnt), 32'd0);
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_m_last", 32'(m_last), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        load(16'h0051, 1'b0, 1'b1);
        load(16'h0052, 1'b0, 1'b1);
        load(16'h0053, 1'b0, 1'b1);
        load(16'h0054, 1'b1, 1'b1);
        m_ready = 1'b1;
        wait_hs(4, "post_rst_done");
        chk("post_rst_burst_cnt", 32'(burst_cnt), 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
